// File: rtl/flt2int_seq_if.sv
// ---------------------------------------------------------------------------
// flt2int_seq_if -- byte-wide data memory port used by flt2int_seq.
//
// Signals:
//   mem_addr  [ADDR_W-1:0]  byte address
//   mem_rd                  read strobe
//   mem_wr                  write strobe
//   mem_wdata [7:0]         write data
//   mem_rdata [7:0]         read data, combinational from mem_addr
//
// Modports:
//   master  -- the converter (drives address/strobes/wdata, reads rdata)
//   slave   -- the memory model (returns rdata)
// ---------------------------------------------------------------------------
interface flt2int_seq_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        output mem_addr,
        output mem_rd,
        output mem_wr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        input  mem_wr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/flt2int_seq.sv
// ---------------------------------------------------------------------------
// flt2int_seq -- sequential half-precision float to signed integer converter.
//
// Each job (started by a falling edge of start seen in IDLE) converts N_ITEMS
// little-endian IEEE halves starting at SRC_BASE into little-endian signed
// OUT_W-bit integers written from DST_BASE, saturating out-of-range values.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   start      job request; the job begins on its falling edge
//   done       one-cycle pulse when the job completes
//   busy       high from the job start edge through the done cycle
//   sat_count  number of saturated items in the current or last job (holds at 127)
//   bus        byte-wide memory master port (flt2int_seq_if.master)
//
// Optional feature macro: FLT2INT_ROUND_EN
//   defined   -> round to nearest even on the guard/sticky bits
//   undefined -> truncate toward zero
// ---------------------------------------------------------------------------
module flt2int_seq #(
    parameter int OUT_W    = 16,
    parameter int N_ITEMS  = 1,
    parameter int SRC_BASE = 4,
    parameter int DST_BASE = 6,
    parameter int ADDR_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 done,
    output logic                 busy,
    output logic [6:0]           sat_count,
    flt2int_seq_if.master        bus
);
    localparam int B    = OUT_W / 8;
    localparam int BI_W = $clog2(B);

    // Saturation limits on the rounded magnitude, and the saturated results.
    localparam logic [OUT_W:0]   POS_LIM = {2'b00, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W:0]   NEG_LIM = {2'b01, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] MAX_RES = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_RES = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, CONV, WR, DONE} state_t;

    state_t            state_reg, state_next;
    logic              start_q;
    logic [6:0]        item_idx_reg;
    logic [BI_W-1:0]   byte_idx_reg;
    logic [7:0]        lo_reg, hi_reg;
    logic [OUT_W-1:0]  result_reg;
    logic [6:0]        sat_count_reg;

    logic trigger, last_byte, last_item;
    assign trigger   = start_q && !start;
    assign last_byte = (byte_idx_reg == BI_W'(B-1));
    assign last_item = (item_idx_reg == 7'(N_ITEMS-1));

    // ---------------- conversion datapath ----------------
    logic [15:0]      f;
    logic             f_s;
    logic [4:0]       f_e, e_eff;
    logic [9:0]       f_m;
    logic [10:0]      sig;
    logic [15:0]      int_part;
    logic             rnd_inc;
    logic [OUT_W:0]   mag_rnd;
    logic             is_nan, exp_big, mag_over, conv_sat;
    logic [OUT_W-1:0] conv_result;

    assign f     = {hi_reg, lo_reg};
    assign f_s   = f[15];
    assign f_e   = f[14:10];
    assign f_m   = f[9:0];
    assign sig   = {f_e != 5'd0, f_m};
    assign e_eff = (f_e == 5'd0) ? 5'd1 : f_e;

    // Shifting sig left by e_eff yields the value scaled by 2^25, so bits
    // [40:25] are the integer part and [24:0] the discarded fraction. This
    // covers both the left (e_eff>25) and right (e_eff<25) shift cases.
    assign int_part = 16'(({30'b0, sig} << e_eff) >> 25);

`ifdef FLT2INT_ROUND_EN
    logic [24:0] frac;
    assign frac    = 25'({30'b0, sig} << e_eff);
    // guard = frac[24], sticky = |frac[23:0]; ties go to the even integer.
    assign rnd_inc = frac[24] & ((|frac[23:0]) | int_part[0]);
`else
    assign rnd_inc = 1'b0;
`endif

    always_comb begin
        mag_rnd  = {{(OUT_W-15){1'b0}}, int_part} + (OUT_W+1)'(rnd_inc);
        is_nan   = (f_e == 5'd31) && (f_m != 10'd0);
        exp_big  = (int'(f_e) - 15) >= (OUT_W - 1);
        mag_over = f_s ? (mag_rnd > NEG_LIM) : (mag_rnd > POS_LIM);
        conv_sat = (f_e == 5'd31) || exp_big || mag_over;
        if (conv_sat)
            conv_result = (f_s && !is_nan) ? MIN_RES : MAX_RES;
        else if (f_s)
            conv_result = -mag_rnd[OUT_W-1:0];
        else
            conv_result = mag_rnd[OUT_W-1:0];
    end

    // Result split into bytes so the write mux indexes a B-entry array.
    logic [7:0] res_bytes [B];
    generate
        for (genvar gi = 0; gi < B; gi++) begin : g_bytes
            assign res_bytes[gi] = result_reg[8*gi +: 8];
        end
    endgenerate

    // ---------------- FSM: next state and outputs ----------------
    always_comb begin
        state_next    = state_reg;
        bus.mem_addr  = '0;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_wdata = 8'd0;
        done          = 1'b0;
        busy          = (state_reg != IDLE);
        case (state_reg)
            IDLE: if (trigger) state_next = RD_LO;
            RD_LO: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = ADDR_W'(SRC_BASE + 2*int'(item_idx_reg));
                state_next   = RD_HI;
            end
            RD_HI: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = ADDR_W'(SRC_BASE + 2*int'(item_idx_reg) + 1);
                state_next   = CONV;
            end
            CONV: state_next = WR;
            WR: begin
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = ADDR_W'(DST_BASE + B*int'(item_idx_reg) + int'(byte_idx_reg));
                bus.mem_wdata = res_bytes[byte_idx_reg];
                if (last_byte) state_next = last_item ? DONE : RD_LO;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- state and datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            start_q       <= 1'b0;
            item_idx_reg  <= 7'd0;
            byte_idx_reg  <= '0;
            lo_reg        <= 8'd0;
            hi_reg        <= 8'd0;
            result_reg    <= '0;
            sat_count_reg <= 7'd0;
        end else begin
            state_reg <= state_next;
            start_q   <= start;
            case (state_reg)
                IDLE: if (trigger) begin
                    sat_count_reg <= 7'd0;
                    item_idx_reg  <= 7'd0;
                    byte_idx_reg  <= '0;
                end
                RD_LO: lo_reg <= bus.mem_rdata;
                RD_HI: hi_reg <= bus.mem_rdata;
                CONV: begin
                    result_reg <= conv_result;
                    if (conv_sat && sat_count_reg != 7'd127)
                        sat_count_reg <= sat_count_reg + 7'd1;
                end
                WR: begin
                    if (last_byte) begin
                        byte_idx_reg <= '0;
                        if (!last_item) item_idx_reg <= item_idx_reg + 7'd1;
                    end else begin
                        byte_idx_reg <= byte_idx_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sat_count = sat_count_reg;

endmodule

// File: tb/tb_flt2int_seq.sv
// ---------------------------------------------------------------------------
// tb_flt2int_seq -- directed bench for flt2int_seq.
// Three instances: u0 (OUT_W=16, N_ITEMS=1), u1 (OUT_W=32, N_ITEMS=1),
// u2 (OUT_W=16, N_ITEMS=3). Expected memory writes are queued when a job is
// launched and popped by per-instance write monitors.
// ---------------------------------------------------------------------------
module tb_flt2int_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s   [3];
    logic       start_s [3];
    logic       done_s  [3];
    logic       busy_s  [3];
    logic [6:0] sat_s   [3];

    flt2int_seq_if #(.ADDR_W(8)) bus0 ();
    flt2int_seq_if #(.ADDR_W(8)) bus1 ();
    flt2int_seq_if #(.ADDR_W(8)) bus2 ();

    logic [7:0] src0 [256];
    logic [7:0] src1 [256];
    logic [7:0] src2 [256];

    assign bus0.mem_rdata = src0[bus0.mem_addr];
    assign bus1.mem_rdata = src1[bus1.mem_addr];
    assign bus2.mem_rdata = src2[bus2.mem_addr];

    flt2int_seq #(.OUT_W(16), .N_ITEMS(1)) u0 (
        .clk(clk), .reset(rst_s[0]), .start(start_s[0]), .done(done_s[0]),
        .busy(busy_s[0]), .sat_count(sat_s[0]), .bus(bus0));
    flt2int_seq #(.OUT_W(32), .N_ITEMS(1)) u1 (
        .clk(clk), .reset(rst_s[1]), .start(start_s[1]), .done(done_s[1]),
        .busy(busy_s[1]), .sat_count(sat_s[1]), .bus(bus1));
    flt2int_seq #(.OUT_W(16), .N_ITEMS(3)) u2 (
        .clk(clk), .reset(rst_s[2]), .start(start_s[2]), .done(done_s[2]),
        .busy(busy_s[2]), .sat_count(sat_s[2]), .bus(bus2));

    typedef struct packed {
        logic [1:0] dut;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mon_write(input logic [1:0] d, input logic [7:0] a, input logic [7:0] w);
        wr_t e;
        tests++;
        assert (exp_q.size() > 0) else begin
            fails++;
            $error("FAIL wr_extra: dut %0d wrote %0h at %0h, expected no write", d, w, a);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wr_dut", 32'(d), 32'(e.dut));
            check("wr_addr", 32'(a), 32'(e.addr));
            check("wr_data", 32'(w), 32'(e.data));
            $display("[TB] dut%0d write addr=%0h data=%0h", d, a, w);
        end
    endtask

    always @(negedge clk) if (bus0.mem_wr === 1'b1) mon_write(2'd0, bus0.mem_addr, bus0.mem_wdata);
    always @(negedge clk) if (bus1.mem_wr === 1'b1) mon_write(2'd1, bus1.mem_addr, bus1.mem_wdata);
    always @(negedge clk) if (bus2.mem_wr === 1'b1) mon_write(2'd2, bus2.mem_addr, bus2.mem_wdata);

    task automatic set_src(input int d, input int a, input logic [7:0] v);
        case (d)
            0: src0[a] = v;
            1: src1[a] = v;
            default: src2[a] = v;
        endcase
    endtask

    // Loads operands and queues the expected writes for an n-item job.
    task automatic prep_job(input int d, input int n, input int b,
                            input logic [15:0] f0, input logic [15:0] f1, input logic [15:0] f2,
                            input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2,
                            input int n_writes);
        logic [15:0] fs [3];
        logic [31:0] rs [3];
        wr_t e;
        int cnt;
        fs[0] = f0; fs[1] = f1; fs[2] = f2;
        rs[0] = r0; rs[1] = r1; rs[2] = r2;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            set_src(d, 4 + 2*i, fs[i][7:0]);
            set_src(d, 5 + 2*i, fs[i][15:8]);
            for (int k = 0; k < b; k++) begin
                if (cnt < n_writes) begin
                    e.dut  = 2'(d);
                    e.addr = 8'(6 + b*i + k);
                    e.data = rs[i][8*k +: 8];
                    exp_q.push_back(e);
                end
                cnt++;
            end
        end
    endtask

    // Start drops at a negedge; the following posedge is the trigger edge.
    task automatic pulse_start(input int d);
        @(negedge clk) start_s[d] = 1'b1;
        @(negedge clk) start_s[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int lat, input int exp_sat, input string tag);
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (k == 0) check($sformatf("%s.busy_rise", tag), 32'(busy_s[d]), 32'd1);
            if (done_s[d] === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            n++;
        end
        check($sformatf("%s.done_seen", tag), 32'(seen), 32'd1);
        check($sformatf("%s.latency", tag), 32'(n), 32'(lat));
        check($sformatf("%s.busy_done", tag), 32'(busy_s[d]), 32'd1);
        check($sformatf("%s.sat", tag), 32'(sat_s[d]), 32'(exp_sat));
        @(negedge clk);
        check($sformatf("%s.done_1cyc", tag), 32'(done_s[d]), 32'd0);
        check($sformatf("%s.busy_fall", tag), 32'(busy_s[d]), 32'd0);
        check($sformatf("%s.q_drained", tag), 32'(exp_q.size()), 32'd0);
        $display("[TB] dut%0d job %s latency=%0d sat=%0d", d, tag, n, sat_s[d]);
    endtask

    task automatic job16(input logic [15:0] f, input logic [31:0] r, input int sat, input string tag);
        prep_job(0, 1, 2, f, 16'h0, 16'h0, r, 32'h0, 32'h0, 2);
        pulse_start(0);
        wait_done(0, 5, sat, tag);
    endtask

    task automatic job32(input logic [15:0] f, input logic [31:0] r, input int sat, input string tag);
        prep_job(1, 1, 4, f, 16'h0, 16'h0, r, 32'h0, 32'h0, 4);
        pulse_start(1);
        wait_done(1, 7, sat, tag);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcount;
        for (int i = 0; i < 256; i++) begin
            src0[i] = 8'h00; src1[i] = 8'h00; src2[i] = 8'h00;
        end
        for (int d = 0; d < 3; d++) begin
            rst_s[d]   = 1'b1;
            start_s[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.done", 32'(done_s[0]), 32'd0);
        check("rst.busy", 32'(busy_s[0]), 32'd0);
        check("rst.rd", 32'(bus0.mem_rd), 32'd0);
        check("rst.wr", 32'(bus0.mem_wr), 32'd0);
        check("rst.addr", 32'(bus0.mem_addr), 32'd0);
        check("rst.wdata", 32'(bus0.mem_wdata), 32'd0);
        check("rst.sat0", 32'(sat_s[0]), 32'd0);
        check("rst.sat2", 32'(sat_s[2]), 32'd0);
        for (int d = 0; d < 3; d++) rst_s[d] = 1'b0;

        // OUT_W=16, single item
        job16(16'h3C00, 32'h0001, 0, "one");
        job16(16'hC500, 32'hFFFB, 0, "neg5");
        job16(16'hFC00, 32'h8000, 1, "neginf");
        job16(16'h7BFF, 32'h7FFF, 1, "max_half");
`ifdef FLT2INT_ROUND_EN
        job16(16'h3E00, 32'h0002, 0, "p1_5");
        job16(16'hBE00, 32'hFFFE, 0, "n1_5");
`else
        job16(16'h3E00, 32'h0001, 0, "p1_5");
        job16(16'hBE00, 32'hFFFF, 0, "n1_5");
`endif
        job16(16'h4100, 32'h0002, 0, "p2_5");
        job16(16'h3800, 32'h0000, 0, "p0_5");
        job16(16'h0001, 32'h0000, 0, "subnorm");
        job16(16'h8000, 32'h0000, 0, "negzero");
        job16(16'h7E00, 32'h7FFF, 1, "nan");
        job16(16'hFE00, 32'h7FFF, 1, "negnan");
        job16(16'h77FF, 32'h7FF0, 0, "e29");
        job16(16'hF800, 32'h8000, 1, "neg32768");

        // OUT_W=32, single item
        job32(16'h7BFF, 32'h0000FFE0, 0, "w32_max_half");
        job32(16'hC500, 32'hFFFFFFFB, 0, "w32_neg5");
        job32(16'hFC00, 32'h80000000, 1, "w32_neginf");

        // N_ITEMS=3
        prep_job(2, 3, 2, 16'h3C00, 16'hBC00, 16'h7E00, 32'h0001, 32'hFFFF, 32'h7FFF, 6);
        pulse_start(2);
        wait_done(2, 15, 1, "multi");

        // Reset during WR_0 of item 1: only the first three bytes may land.
        prep_job(2, 3, 2, 16'h7E00, 16'hBC00, 16'h3C00, 32'h7FFF, 32'hFFFF, 32'h0001, 3);
        pulse_start(2);
        @(posedge clk);
        repeat (8) @(posedge clk);
        #1;
        check("mid.wr", 32'(bus2.mem_wr), 32'd1);
        check("mid.addr", 32'(bus2.mem_addr), 32'd8);
        check("mid.sat", 32'(sat_s[2]), 32'd1);
        rst_s[2] = 1'b1;
        @(posedge clk);
        #1;
        rst_s[2] = 1'b0;
        check("mid.busy", 32'(busy_s[2]), 32'd0);
        check("mid.sat_clr", 32'(sat_s[2]), 32'd0);
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_s[2] === 1'b1) dcount++;
        end
        check("mid.no_done", 32'(dcount), 32'd0);
        check("mid.q_drained", 32'(exp_q.size()), 32'd0);
        check("mid.busy_idle", 32'(busy_s[2]), 32'd0);
        $display("[TB] dut2 reset-in-job done_pulses=%0d", dcount);

        // Fresh job after the reset
        prep_job(2, 3, 2, 16'h3C00, 16'hBC00, 16'h7E00, 32'h0001, 32'hFFFF, 32'h7FFF, 6);
        pulse_start(2);
        wait_done(2, 15, 1, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
